// File: rtl/fsm_bn_pkg.sv
// Shared types and default constants for the fsm_bn segment sequencer.
// The ERR state exists only when FSM_BN_TIMEOUT_EN is defined.
package fsm_bn_pkg;

    localparam int NCH_DEF     = 2;
    localparam int CNT_W_DEF   = 16;
    localparam int TMO_CYC_DEF = 255;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_LOAD = 3'd2,
        S_STEP = 3'd3,
        S_OUT  = 3'd4,
`ifdef FSM_BN_TIMEOUT_EN
        S_DONE = 3'd5,
        S_ERR  = 3'd6
`else
        S_DONE = 3'd5
`endif
    } state_t;

endpackage

// File: rtl/fsm_bn_ack_join.sv
// Per-channel step-ack collector: latches acks while enabled and flags when
// every channel has answered (including acks arriving in the current cycle).
module ack_join #(
    parameter int NCH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_en,
    input  logic [NCH-1:0] i_ack,
    output logic [NCH-1:0] o_pend,
    output logic           o_all_acked
);

    logic [NCH-1:0] r_seen;
    logic [NCH-1:0] w_seen_nxt;

    // Acks outside the enabled window are masked so they cannot pre-load the join.
    always_comb begin
        w_seen_nxt  = r_seen | (i_en ? i_ack : {NCH{1'b0}});
        o_pend      = ~w_seen_nxt;
        o_all_acked = i_en & (&w_seen_nxt);
    end

    // Seen bits clear on reset, on completion and whenever the join is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seen <= {NCH{1'b0}};
        end else if (o_all_acked || !i_en) begin
            r_seen <= {NCH{1'b0}};
        end else begin
            r_seen <= w_seen_nxt;
        end
    end

endmodule

// File: rtl/fsm_bn.sv
// Segment-drawing handshake sequencer: init unit, NCH Bresenham steppers and
// a downstream pixel port. Optional watchdog/ERR state via FSM_BN_TIMEOUT_EN.
module fsm_bn
    import fsm_bn_pkg::*;
#(
    parameter int NCH     = NCH_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_in,
    output logic             ack_in,
    output logic             req_init,
    input  logic             ack_init,
    output logic             init_br,
    output logic [NCH-1:0]   req_int,
    input  logic [NCH-1:0]   ack_int,
    output logic             req_out,
    input  logic             ack_out,
    input  logic             eoc,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] step_cnt,
    output logic             err
);

    state_t         r_state;
    logic           r_eoc_seen;
    logic [NCH-1:0] w_pend;
    logic           w_all_acked;

    ack_join #(.NCH(NCH)) u_ack_join (
        .clk         (clk),
        .rst         (rst),
        .i_en        (r_state == S_STEP),
        .i_ack       (ack_int),
        .o_pend      (w_pend),
        .o_all_acked (w_all_acked)
    );

`ifdef FSM_BN_TIMEOUT_EN
    localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC + 1) : 1;

    logic [TW-1:0] r_wdog;
    logic          w_wait;
    logic          w_leave;
    logic          w_tmo;

    // A wait state times out only on a cycle where it would not have advanced anyway.
    always_comb begin
        w_wait  = (r_state == S_INIT) || (r_state == S_STEP) || (r_state == S_OUT);
        w_leave = ((r_state == S_INIT) && ack_init) ||
                  ((r_state == S_STEP) && w_all_acked) ||
                  ((r_state == S_OUT)  && ack_out);
        w_tmo   = w_wait && !w_leave && (r_wdog == TW'(TMO_CYC - 1));
    end

    // Watchdog counts cycles spent in the current wait state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= {TW{1'b0}};
        end else if (w_wait && !w_leave && !w_tmo) begin
            r_wdog <= r_wdog + TW'(1);
        end else begin
            r_wdog <= {TW{1'b0}};
        end
    end
`else
    assign err = 1'b0;
`endif

    // Main sequencer; every output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_eoc_seen <= 1'b0;
            ack_in     <= 1'b0;
            req_init   <= 1'b0;
            init_br    <= 1'b0;
            req_int    <= {NCH{1'b0}};
            req_out    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            step_cnt   <= {CNT_W{1'b0}};
`ifdef FSM_BN_TIMEOUT_EN
            err        <= 1'b0;
`endif
        end else begin
            ack_in  <= 1'b0;
            init_br <= 1'b0;
            done    <= 1'b0;
            if (((r_state == S_STEP) || (r_state == S_OUT)) && eoc) begin
                r_eoc_seen <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (req_in) begin
                        ack_in   <= 1'b1;
                        req_init <= 1'b1;
                        busy     <= 1'b1;
                        step_cnt <= {CNT_W{1'b0}};
                        r_state  <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (ack_init) begin
                        req_init <= 1'b0;
                        init_br  <= 1'b1;
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    req_int <= {NCH{1'b1}};
                    r_state <= S_STEP;
                end
                S_STEP: begin
                    if (w_all_acked) begin
                        req_int <= {NCH{1'b0}};
                        req_out <= 1'b1;
                        r_state <= S_OUT;
                    end else begin
                        req_int <= w_pend;
                    end
                end
                S_OUT: begin
                    if (ack_out) begin
                        req_out <= 1'b0;
                        if (step_cnt != {CNT_W{1'b1}}) begin
                            step_cnt <= step_cnt + CNT_W'(1);
                        end
                        if (r_eoc_seen || eoc) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            req_int <= {NCH{1'b1}};
                            r_state <= S_STEP;
                        end
                    end
                end
                S_DONE: begin
                    r_eoc_seen <= 1'b0;
                    busy       <= 1'b0;
                    r_state    <= S_IDLE;
                end
`ifdef FSM_BN_TIMEOUT_EN
                S_ERR: begin
                    req_init <= 1'b0;
                    req_int  <= {NCH{1'b0}};
                    req_out  <= 1'b0;
                end
`endif
                default: begin
                    req_init <= 1'b0;
                    req_int  <= {NCH{1'b0}};
                    req_out  <= 1'b0;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
`ifdef FSM_BN_TIMEOUT_EN
            if (w_tmo) begin
                err      <= 1'b1;
                req_init <= 1'b0;
                req_int  <= {NCH{1'b0}};
                req_out  <= 1'b0;
                init_br  <= 1'b0;
                r_state  <= S_ERR;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fsm_bn.sv
// Directed self-checking bench for fsm_bn (NCH=2, CNT_W=2, TMO_CYC=8).
// The watchdog scenario runs only when FSM_BN_TIMEOUT_EN is defined.
module tb_fsm_bn;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_in = 1'b0;
    logic       ack_in;
    logic       req_init;
    logic       ack_init = 1'b0;
    logic       init_br;
    logic [1:0] req_int;
    logic [1:0] ack_int = 2'b00;
    logic       req_out;
    logic       ack_out = 1'b0;
    logic       eoc = 1'b0;
    logic       busy;
    logic       done;
    logic [1:0] step_cnt;
    logic       err;

    int n_vec = 0;
    int n_bad = 0;

    fsm_bn #(.NCH(2), .CNT_W(2), .TMO_CYC(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_in),
        .ack_in   (ack_in),
        .req_init (req_init),
        .ack_init (ack_init),
        .init_br  (init_br),
        .req_int  (req_int),
        .ack_int  (ack_int),
        .req_out  (req_out),
        .ack_out  (ack_out),
        .eoc      (eoc),
        .busy     (busy),
        .done     (done),
        .step_cnt (step_cnt),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_segment();
        req_in = 1'b1;
        tick();
        req_in = 1'b0;
        chk("start_ack_in", ack_in, 1);
        chk("start_cnt_clr", step_cnt, 0);
        ack_init = 1'b1;
        tick();
        ack_init = 1'b0;
        chk("start_init_br", init_br, 1);
        tick();
        chk("start_req_int", req_int, 2'b11);
    endtask

    // one pixel: both channels ack together, then downstream accepts
    task automatic pixel(input logic eoc_step, input logic eoc_out, input logic [1:0] exp_cnt, input logic exp_done);
        ack_int = 2'b11;
        eoc     = eoc_step;
        tick();
        ack_int = 2'b00;
        eoc     = 1'b0;
        chk("px_req_out", req_out, 1);
        ack_out = 1'b1;
        eoc     = eoc_out;
        tick();
        ack_out = 1'b0;
        eoc     = 1'b0;
        chk("px_cnt", step_cnt, exp_cnt);
        chk("px_done", done, exp_done);
        chk("px_req_int", req_int, exp_done ? 2'b00 : 2'b11);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_outs", {ack_in, req_init, init_br, req_int, req_out, done, err}, 0);
        chk("rst_cnt", step_cnt, 0);

        // spurious handshakes while idle must be ignored
        ack_init = 1'b1; ack_int = 2'b11; ack_out = 1'b1;
        tick();
        ack_init = 1'b0; ack_int = 2'b00; ack_out = 1'b0;
        chk("idle_spurious", {busy, req_init, init_br, req_int, req_out}, 0);

        // segment 1: ack_init after 3 cycles, staggered stepper acks
        req_in = 1'b1;
        tick();
        req_in = 1'b0;
        chk("s1_ack_in", ack_in, 1);
        chk("s1_req_init", req_init, 1);
        chk("s1_busy", busy, 1);
        tick();
        chk("s1_ack_in_pulse", ack_in, 0);
        ack_out = 1'b1; ack_int = 2'b11;
        tick();
        ack_out = 1'b0; ack_int = 2'b00;
        chk("s1_init_hold", {req_init, init_br, req_int, req_out}, 5'b10000);
        ack_init = 1'b1;
        tick();
        ack_init = 1'b0;
        chk("s1_req_init_drop", req_init, 0);
        chk("s1_init_br", init_br, 1);
        tick();
        chk("s1_init_br_pulse", init_br, 0);
        chk("s1_req_int", req_int, 2'b11);
        ack_int = 2'b01;
        tick();
        ack_int = 2'b00;
        for (int i = 1; i <= 3; i++) begin
            chk("s1_req_int_partial", req_int, 2'b10);
            chk("s1_no_req_out", req_out, 0);
            tick();
        end
        chk("s1_req_int_t4", req_int, 2'b10);
        ack_int = 2'b10;
        tick();
        ack_int = 2'b00;
        chk("s1_req_out_t5", req_out, 1);
        chk("s1_req_int_off", req_int, 2'b00);
        tick();
        chk("s1_req_out_hold", req_out, 1);
        ack_out = 1'b1;
        tick();
        ack_out = 1'b0;
        chk("s1_cnt1", step_cnt, 1);
        chk("s1_back_step", {req_out, req_int}, 3'b011);
        pixel(1'b0, 1'b0, 2'd2, 1'b0);
        pixel(1'b0, 1'b1, 2'd3, 1'b1);
        tick();
        chk("s1_done_once", done, 0);
        chk("s1_busy_off", busy, 0);
        chk("s1_cnt_hold", step_cnt, 3);

        // segment 2: five pixels saturate a 2-bit counter; eoc seen during STEP
        start_segment();
        pixel(1'b0, 1'b0, 2'd1, 1'b0);
        pixel(1'b0, 1'b0, 2'd2, 1'b0);
        pixel(1'b0, 1'b0, 2'd3, 1'b0);
        pixel(1'b0, 1'b0, 2'd3, 1'b0);
        pixel(1'b1, 1'b0, 2'd3, 1'b1);
        tick();
        chk("s2_busy_off", busy, 0);

        // segment 3: reset while waiting in OUT
        start_segment();
        ack_int = 2'b11;
        tick();
        ack_int = 2'b00;
        chk("s3_in_out", req_out, 1);
        rst = 1'b1; req_in = 1'b1; ack_out = 1'b1;
        tick();
        rst = 1'b0; req_in = 1'b0; ack_out = 1'b0;
        chk("s3_rst_outs", {ack_in, req_init, init_br, req_int, req_out, busy, done, err}, 0);
        chk("s3_rst_cnt", step_cnt, 0);
        ack_out = 1'b1;
        tick();
        ack_out = 1'b0;
        chk("s3_idle_after_rst", {busy, step_cnt, done}, 0);

`ifdef FSM_BN_TIMEOUT_EN
        // segment 4: downstream never accepts; watchdog trips after 8 cycles in OUT
        start_segment();
        ack_int = 2'b11;
        tick();
        ack_int = 2'b00;
        for (int i = 0; i < 7; i++) begin
            chk("s4_pre_tmo_req_out", req_out, 1);
            chk("s4_pre_tmo_err", err, 0);
            tick();
        end
        chk("s4_last_wait", {req_out, err}, 2'b10);
        tick();
        chk("s4_err", err, 1);
        chk("s4_reqs_off", {req_init, req_int, req_out}, 0);
        ack_out = 1'b1; req_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        ack_out = 1'b0; req_in = 1'b0;
        chk("s4_err_sticky", {err, busy, req_out, ack_in}, 4'b1100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s4_err_cleared", {err, busy}, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/fsm_bn.md
FSM_BN -- requirements
Module: fsm_bn

Interface
REQ-001 Parameter NCH, 2, number of parallel internal Bresenham stepper channels (1..8).
REQ-002 Parameter CNT_W, 16, width of step counter.
REQ-003 Parameter TMO_CYC, 255, watchdog limit in cycles per wait state; used only with FSM_BN_TIMEOUT_EN.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req_in  in  1  upstream request to draw one segment.
REQ-008 ack_in  out  1  one-cycle acceptance pulse for req_in.
REQ-009 req_init  out  1  request to init unit, held until ack_init.
REQ-010 ack_init  in  1  init unit done.
REQ-011 init_br  out  1  one-cycle load pulse to Bresenham registers.
REQ-012 req_int  out  NCH  per-channel step request.
REQ-013 ack_int  in  NCH  per-channel step acknowledge.
REQ-014 req_out  out  1  pixel available to downstream, held until ack_out.
REQ-015 ack_out  in  1  downstream accepted pixel.
REQ-016 eoc  in  1  end-of-segment flag from steppers.
REQ-017 busy  out  1  high whenever state is not IDLE.
REQ-018 done  out  1  one-cycle pulse at segment completion.
REQ-019 step_cnt  out  CNT_W  pixels emitted in current segment.
REQ-020 err  out  1  watchdog error, sticky.

Function
REQ-021 States SHALL be IDLE, INIT, LOAD, STEP, OUT, DONE, ERR (ERR only with macro).
REQ-022 IDLE: on req_in=1, ack_in=1 for that cycle, step_cnt cleared, next state INIT; req_in ignored in all other states.
REQ-023 INIT: req_init=1; when ack_init sampled 1, req_init drops next cycle and state goes LOAD.
REQ-024 LOAD: init_br=1 for exactly one cycle, next state STEP; latency req_in to first req_int >= 3 cycles.
REQ-025 STEP: req_int[i]=1 while channel i not yet acked; ack_int[i] latched in ack_seen[i]; req_int[i] drops the cycle after its ack.
REQ-026 STEP exits to OUT in the cycle after all NCH acks are collected, whether simultaneous or staggered; ack_seen cleared on exit.
REQ-027 OUT: req_out=1 until ack_out sampled 1; on that cycle step_cnt increments, saturating at all-ones.
REQ-028 eoc sampled 1 at any cycle in STEP or OUT SHALL set eoc_seen; on ack_out, eoc_seen or eoc high -> DONE, else -> STEP.
REQ-029 DONE: done=1 for one cycle, eoc_seen cleared, next state IDLE; step_cnt holds until next accepted req_in.
REQ-030 Spurious ack_int, ack_init or ack_out outside its waiting state SHALL be ignored.

Reset
REQ-031 On rst=1 at a clock edge, state=IDLE and all outputs, step_cnt, ack_seen, eoc_seen and watchdog = 0, including mid-operation; rst overrides all other inputs.

Configuration
REQ-032 With FSM_BN_TIMEOUT_EN defined: a watchdog counter clears on every state change; if it reaches TMO_CYC in INIT, STEP or OUT, state goes ERR, err=1, all req outputs 0; ERR exits only by rst.
REQ-033 Without FSM_BN_TIMEOUT_EN: no watchdog logic, no ERR state, err tied 0.

Structure
REQ-034 Package fsm_bn_pkg SHALL hold the state enum typedef and default parameter constants.
REQ-035 Per-channel ack latching and all-acked detection SHALL be sub-module ack_join (parameter NCH).

Verification
REQ-036 NCH=2: req_in pulse, ack_init after 3 cycles -> ack_in 1 cycle, init_br 1 cycle, req_int=2'b11.
REQ-037 ack_int[0] at t, ack_int[1] at t+4 -> req_int=2'b10 from t+1, req_out rises t+5.
REQ-038 Three ack_out cycles, eoc with third -> step_cnt=3, done pulse once, busy 0 afterwards.
REQ-039 rst asserted during OUT -> next edge all outputs 0, state IDLE, step_cnt=0.
REQ-040 Macro on, TMO_CYC=8, ack_out withheld -> err=1 after 8 cycles in OUT, req_out=0, held until rst.
REQ-041 CNT_W=2, five pixels before eoc -> step_cnt saturates at 3.
